// File: rtl/rr_first_one_arbiter.sv
// Registered round-robin arbiter: rotating find-first-one search from a priority
// pointer, one-hot grant held until ack or MAX_HOLD timeout.
`timescale 1ns/1ps

module rr_first_one_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 0,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic           ack,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           timeout
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam int IW = IDW + 1;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    logic           r_state;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_gnt_id;
    logic [IDW-1:0] r_ptr;
    logic [HW-1:0]  r_hold;
    logic           r_timeout;

    logic [IDW-1:0] w_win_id;
    logic           w_found;
    logic [N-1:0]   w_win_onehot;
    logic [IDW-1:0] w_next_ptr;
    logic           w_hold_expired;

    // Rotating search: visit ptr, ptr+1, ... wrapping modulo N; first hit wins.
    always_comb begin
        logic [IW-1:0] idx;
        // NOTE: every comb output gets a default before the loop so no path leaves it unassigned (no latch).
        w_win_id = '0;
        w_found  = 1'b0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = {1'b0, r_ptr} + IW'(k);
            if (idx >= IW'(N)) begin
                idx = idx - IW'(N);
            end
            if (!w_found && req[idx[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_win_id = idx[IDW-1:0];
            end
        end
    end

    assign w_win_onehot   = N'(1) << w_win_id;
    assign w_next_ptr     = (r_gnt_id == IDW'(N - 1)) ? '0 : r_gnt_id + IDW'(1);
    assign w_hold_expired = (MAX_HOLD > 0) && (r_hold == HW'(MAX_HOLD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_gnt     <= '0;
            r_gnt_id  <= '0;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking for all state so each register is computed from pre-edge values.
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state  <= ST_GRANT;
                        r_gnt    <= w_win_onehot;
                        r_gnt_id <= w_win_id;
                        r_hold   <= HW'(1);
                    end
                end
                ST_GRANT: begin
                    if (ack || w_hold_expired) begin
                        r_state   <= ST_IDLE;
                        r_gnt     <= '0;
                        r_gnt_id  <= '0;
                        r_ptr     <= w_next_ptr;
                        r_hold    <= '0;
                        // ack takes precedence over a coincident expiry
                        r_timeout <= ~ack;
                    end else if (MAX_HOLD > 0) begin
                        r_hold <= r_hold + HW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = (r_state == ST_GRANT);
    assign gnt_id    = r_gnt_id;
    assign timeout   = r_timeout;

endmodule
